// File: rtl/vend_pkg.sv
// Shared types and constants for the vending session front-end.
package vend_pkg;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StSelect   = 3'd1,
    StCollect  = 3'd2,
    StVend     = 3'd3,
    StWaitDone = 3'd4,
    StRefund   = 3'd5
  } state_e;

  localparam logic [1:0] CoinOne = 2'b00;
  localparam logic [1:0] CoinTwo = 2'b01;
  localparam logic [1:0] CoinFive = 2'b10;
  localparam logic [1:0] CoinTen = 2'b11;

  localparam logic [2:0] ProdPen = 3'b000;
  localparam logic [2:0] ProdNotebook = 3'b001;
  localparam logic [2:0] ProdWater = 3'b100;

  localparam int unsigned MaxTotal = 127;

  function automatic logic [6:0] coin_decode(input logic [1:0] code);
    logic [6:0] val;
    unique case (code)
      CoinOne:  val = 7'd1;
      CoinTwo:  val = 7'd2;
      CoinFive: val = 7'd5;
      default:  val = 7'd10;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/vend_coin_accum.sv
// Coin accumulator: decodes the coin, adds it only if the total stays within MaxTotal.
module vend_coin_accum
  import vend_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       add_i,
  input  logic       clear_i,
  input  logic [1:0] coin_value_i,
  output logic [6:0] total_o,
  output logic       fits_o
);

  logic [6:0] total_q, total_d;
  logic [7:0] sum;

  assign sum    = {1'b0, total_q} + {1'b0, coin_decode(coin_value_i)};
  assign fits_o = (sum <= 8'(MaxTotal));

  always_comb begin
    total_d = total_q;
    if (clear_i) begin
      total_d = '0;
    end else if (add_i && fits_o) begin
      total_d = sum[6:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      total_q <= '0;
    end else begin
      total_q <= total_d;
    end
  end

  assign total_o = total_q;

endmodule

// File: rtl/vend_session_ctrl.sv
// Session sequencer in front of the vending core: selection, payment, vend handshake, refunds.
module vend_session_ctrl
  import vend_pkg::*;
#(
  parameter int unsigned START_CYCLES  = 3,
  parameter int unsigned INACT_TIMEOUT = 1000,
  parameter int unsigned DONE_TIMEOUT  = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sel_valid_i,
  input  logic [2:0] sel_code_i,
  input  logic       coin_valid_i,
  input  logic [1:0] coin_value_i,
  input  logic       pay_online_i,
  input  logic       cancel_btn_i,
  input  logic [6:0] core_price_i,
  input  logic       core_dispense_i,
  output logic       core_start_o,
  output logic [2:0] core_code_o,
  output logic       core_online_o,
  output logic [6:0] core_total_o,
  output logic       core_cancel_o,
  output logic       refund_valid_o,
  output logic [6:0] refund_amount_o,
  output logic       coin_reject_o,
  output logic       sel_error_o,
  output logic       busy_o,
  output logic [2:0] session_state_o
);

  localparam int unsigned StartW = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
  localparam int unsigned InactW = $clog2(INACT_TIMEOUT + 1);
  localparam int unsigned DoneW  = $clog2(DONE_TIMEOUT + 1);

  state_e              state_q;
  logic [StartW-1:0]   start_cnt_q;
  logic [InactW-1:0]   inact_q;
  logic [DoneW-1:0]    done_q;
  logic                core_start_q, core_online_q, core_cancel_q;
  logic [2:0]          core_code_q;
  logic [6:0]          core_total_q, refund_amount_q;
  logic                refund_valid_q, coin_reject_q, sel_error_q;

  logic [6:0] acc;
  logic       coin_fits, coin_add, acc_clear;
  logic       inact_hit, done_hit, acc_zero, paid, online_ok, collect_live;

  assign inact_hit    = (inact_q == InactW'(INACT_TIMEOUT));
  assign done_hit     = (done_q == DoneW'(DONE_TIMEOUT));
  assign acc_zero     = (acc == '0);
  assign paid         = (acc >= core_price_i);
  assign online_ok    = pay_online_i && acc_zero;
  assign collect_live = (state_q == StCollect) && !cancel_btn_i && !inact_hit;
  // Coins only land when nothing higher in the COLLECT priority chain fires.
  assign coin_add     = collect_live && !paid && !online_ok && coin_valid_i && coin_fits;
  assign acc_clear    = (state_q == StRefund) || ((state_q == StWaitDone) && core_dispense_i);

  vend_coin_accum u_accum (
    .clk          (clk),
    .reset        (reset),
    .add_i        (coin_add),
    .clear_i      (acc_clear),
    .coin_value_i (coin_value_i),
    .total_o      (acc),
    .fits_o       (coin_fits)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= StIdle;
      start_cnt_q     <= '0;
      inact_q         <= '0;
      done_q          <= '0;
      core_start_q    <= 1'b0;
      core_code_q     <= '0;
      core_online_q   <= 1'b0;
      core_total_q    <= '0;
      core_cancel_q   <= 1'b0;
      refund_valid_q  <= 1'b0;
      refund_amount_q <= '0;
      coin_reject_q   <= 1'b0;
      sel_error_q     <= 1'b0;
    end else begin
      coin_reject_q   <= 1'b0;
      sel_error_q     <= 1'b0;
      core_cancel_q   <= 1'b0;
      refund_valid_q  <= 1'b0;
      refund_amount_q <= '0;
      unique case (state_q)
        StIdle: begin
          coin_reject_q <= coin_valid_i;
          if (sel_valid_i) begin
            core_code_q <= sel_code_i;
            state_q     <= StSelect;
          end
        end
        StSelect: begin
          coin_reject_q <= coin_valid_i;
          if (core_price_i == '0) begin
            sel_error_q <= 1'b1;
            state_q     <= StIdle;
          end else begin
            inact_q <= '0;
            state_q <= StCollect;
          end
        end
        StCollect: begin
          if (coin_add) begin
            inact_q <= '0;
          end else if (!inact_hit) begin
            inact_q <= inact_q + 1'b1;
          end
          if (cancel_btn_i || inact_hit) begin
            coin_reject_q <= coin_valid_i;
            state_q       <= StRefund;
          end else if (paid || online_ok) begin
            coin_reject_q <= coin_valid_i;
            core_start_q  <= 1'b1;
            core_online_q <= !paid;
            core_total_q  <= paid ? acc : 7'd0;
            start_cnt_q   <= '0;
            state_q       <= StVend;
          end else if (coin_valid_i) begin
            coin_reject_q <= !coin_fits;
          end else if (sel_valid_i && acc_zero) begin
            core_code_q <= sel_code_i;
            state_q     <= StSelect;
          end
        end
        StVend: begin
          coin_reject_q <= coin_valid_i;
          if (start_cnt_q == StartW'(START_CYCLES - 1)) begin
            core_start_q  <= 1'b0;
            core_total_q  <= '0;
            core_online_q <= 1'b0;
            done_q        <= '0;
            state_q       <= StWaitDone;
          end else begin
            start_cnt_q <= start_cnt_q + 1'b1;
          end
        end
        StWaitDone: begin
          coin_reject_q <= coin_valid_i;
          if (core_dispense_i) begin
            state_q <= StIdle;
          end else if (done_hit) begin
            core_cancel_q <= 1'b1;
            state_q       <= StRefund;
          end else begin
            done_q <= done_q + 1'b1;
          end
        end
        StRefund: begin
          coin_reject_q   <= coin_valid_i;
          refund_valid_q  <= 1'b1;
          refund_amount_q <= acc;
          state_q         <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign core_start_o    = core_start_q;
  assign core_code_o     = core_code_q;
  assign core_online_o   = core_online_q;
  assign core_total_o    = core_total_q;
  assign core_cancel_o   = core_cancel_q;
  assign refund_valid_o  = refund_valid_q;
  assign refund_amount_o = refund_amount_q;
  assign coin_reject_o   = coin_reject_q;
  assign sel_error_o     = sel_error_q;
  assign busy_o          = (state_q != StIdle);
  assign session_state_o = state_q;

endmodule

// File: tb/tb_vend_session_ctrl.sv
// Scoreboard bench: stimulus queues expected pulse events, a negedge monitor pops and compares.
module tb_vend_session_ctrl;

  localparam int unsigned StartCycles  = 3;
  localparam int unsigned InactTimeout = 30;
  localparam int unsigned DoneTimeout  = 20;

  localparam int EvCancel = 0;
  localparam int EvRefund = 1;
  localparam int EvSelErr = 2;
  localparam int EvCoinRej = 3;
  localparam int EvStart = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       sel_valid, coin_valid, pay_online, cancel_btn, core_dispense;
  logic [2:0] sel_code;
  logic [1:0] coin_value;
  logic [6:0] core_price;
  logic       core_start, core_online, core_cancel, refund_valid, coin_reject, sel_error, busy;
  logic [2:0] core_code, session_state;
  logic [6:0] core_total, refund_amount;

  typedef struct {
    int          kind;
    logic [15:0] val;
  } ev_t;

  ev_t exp_q[$];
  int  tests_run = 0;
  int  tests_failed = 0;

  logic        run = 1'b0;
  int          run_len = 0;
  logic        stable = 1'b1;
  logic [10:0] cap = '0;

  always #5 clk = ~clk;

  // Core price table: PEN 15, NOTEBOOK 50, WATER 10, code 010 at the 127 ceiling, others invalid.
  function automatic logic [6:0] price_of(input logic [2:0] c);
    case (c)
      3'b000:  return 7'd15;
      3'b001:  return 7'd50;
      3'b100:  return 7'd10;
      3'b010:  return 7'd127;
      default: return 7'd0;
    endcase
  endfunction

  assign core_price = price_of(core_code);

  vend_session_ctrl #(
    .START_CYCLES  (StartCycles),
    .INACT_TIMEOUT (InactTimeout),
    .DONE_TIMEOUT  (DoneTimeout)
  ) u_dut (
    .clk             (clk),
    .reset           (reset),
    .sel_valid_i     (sel_valid),
    .sel_code_i      (sel_code),
    .coin_valid_i    (coin_valid),
    .coin_value_i    (coin_value),
    .pay_online_i    (pay_online),
    .cancel_btn_i    (cancel_btn),
    .core_price_i    (core_price),
    .core_dispense_i (core_dispense),
    .core_start_o    (core_start),
    .core_code_o     (core_code),
    .core_online_o   (core_online),
    .core_total_o    (core_total),
    .core_cancel_o   (core_cancel),
    .refund_valid_o  (refund_valid),
    .refund_amount_o (refund_amount),
    .coin_reject_o   (coin_reject),
    .sel_error_o     (sel_error),
    .busy_o          (busy),
    .session_state_o (session_state)
  );

  function automatic void expect_ev(input int kind, input logic [15:0] val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endfunction

  // Start event = {clean, run length, online, code, total}; clean means stable and zeroed after.
  function automatic logic [15:0] start_val(input logic online, input logic [2:0] code,
                                            input logic [6:0] total);
    return {1'b1, 4'(StartCycles), online, code, total};
  endfunction

  function automatic void got(input int kind, input logic [15:0] val);
    ev_t e;
    tests_run++;
    if (exp_q.size() == 0) begin
      tests_failed++;
      $display("FAIL unexpected_event: got kind %0d val %h, required no event", kind, val);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val != val) begin
        tests_failed++;
        $display("FAIL event: got kind %0d val %h, required kind %0d val %h",
                 kind, val, e.kind, e.val);
      end
    end
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      run = 1'b0;
    end else begin
      if (core_cancel) got(EvCancel, 16'h0);
      if (refund_valid) got(EvRefund, {9'h0, refund_amount});
      if (sel_error) got(EvSelErr, 16'h0);
      if (coin_reject) got(EvCoinRej, 16'h0);
      if (core_start) begin
        if (!run) begin
          run     = 1'b1;
          run_len = 1;
          stable  = 1'b1;
          cap     = {core_online, core_code, core_total};
        end else begin
          run_len++;
          if ({core_online, core_code, core_total} != cap) stable = 1'b0;
        end
      end else if (run) begin
        run = 1'b0;
        got(EvStart, {stable && core_total == '0 && !core_online, 4'(run_len), cap});
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic select(input logic [2:0] code);
    sel_valid = 1'b1;
    sel_code  = code;
    tick();
    sel_valid = 1'b0;
    tick();
  endtask

  task automatic coin(input logic [1:0] v);
    coin_valid = 1'b1;
    coin_value = v;
    tick();
    coin_valid = 1'b0;
  endtask

  task automatic pay();
    pay_online = 1'b1;
    tick();
    pay_online = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s, input int limit, input string name);
    int n = 0;
    while (session_state != s && n < limit) begin
      tick();
      n++;
    end
    check(name, 32'(session_state), 32'(s));
  endtask

  task automatic dispense(input string name);
    wait_state(3'd4, 20, name);
    core_dispense = 1'b1;
    tick();
    core_dispense = 1'b0;
    check({name, "_idle"}, {busy, session_state}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    {sel_valid, coin_valid, pay_online, cancel_btn, core_dispense} = '0;
    sel_code   = '0;
    coin_value = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {core_start, core_code, core_online, core_total, core_cancel,
                            refund_valid, refund_amount, coin_reject, sel_error, busy,
                            session_state}, 0);
    reset = 1'b0;
    tick();

    // Coin while idle is rejected
    expect_ev(EvCoinRej, 16'h0);
    coin(2'b11);
    tick();
    check("idle_coin_state", 32'(session_state), 0);

    // Price-0 selection
    expect_ev(EvSelErr, 16'h0);
    select(3'b111);
    check("sel_error_idle", {busy, session_state}, 0);

    // NOTEBOOK, six tens: sixth arrives in the paid cycle
    expect_ev(EvCoinRej, 16'h0);
    expect_ev(EvStart, start_val(1'b0, 3'b001, 7'd50));
    select(3'b001);
    check("collect_state", 32'(session_state), 2);
    repeat (6) coin(2'b11);
    dispense("notebook");

    // WATER 5 + 10 -> total 15, change left to the core
    expect_ev(EvStart, start_val(1'b0, 3'b100, 7'd15));
    select(3'b100);
    coin(2'b10);
    coin(2'b11);
    dispense("water");

    // PEN online
    expect_ev(EvStart, start_val(1'b1, 3'b000, 7'd0));
    select(3'b000);
    pay();
    dispense("pen_online");

    // Re-select with empty accumulator, then pay online
    expect_ev(EvStart, start_val(1'b1, 3'b100, 7'd0));
    select(3'b001);
    select(3'b100);
    pay();
    dispense("reselect");

    // NOTEBOOK 10 + 5, cancel with a coin in the same cycle
    expect_ev(EvCoinRej, 16'h0);
    expect_ev(EvRefund, 16'd15);
    select(3'b001);
    coin(2'b11);
    coin(2'b10);
    cancel_btn = 1'b1;
    coin(2'b11);
    cancel_btn = 1'b0;
    tick();
    check("cancel_idle", {busy, session_state}, 0);

    // Nonzero accumulator: pay_online and sel_valid ignored
    expect_ev(EvRefund, 16'd2);
    select(3'b100);
    coin(2'b01);
    pay();
    sel_valid = 1'b1;
    sel_code  = 3'b000;
    tick();
    sel_valid = 1'b0;
    check("ignored_state", 32'(session_state), 2);
    check("ignored_code", 32'(core_code), 32'(3'b100));
    cancel_btn = 1'b1;
    tick();
    cancel_btn = 1'b0;
    tick();

    // Inactivity timeout refund
    expect_ev(EvRefund, 16'd2);
    select(3'b100);
    coin(2'b01);
    repeat (InactTimeout + 6) tick();
    check("inact_idle", {busy, session_state}, 0);

    // Core never dispenses: core_cancel then full refund
    expect_ev(EvStart, start_val(1'b0, 3'b100, 7'd10));
    expect_ev(EvCancel, 16'h0);
    expect_ev(EvRefund, 16'd10);
    select(3'b100);
    coin(2'b11);
    repeat (StartCycles + DoneTimeout + 8) tick();
    check("done_to_idle", {busy, session_state}, 0);

    // Ceiling: 12x10, an overflowing 10 is rejected, then 5 + 2 reaches 127
    expect_ev(EvCoinRej, 16'h0);
    expect_ev(EvStart, start_val(1'b0, 3'b010, 7'd127));
    select(3'b010);
    repeat (13) coin(2'b11);
    coin(2'b10);
    coin(2'b01);
    dispense("ceiling");

    // Async reset mid-COLLECT discards the accumulator silently
    select(3'b001);
    coin(2'b11);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", {core_code, busy, session_state, refund_valid}, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick();
    expect_ev(EvStart, start_val(1'b1, 3'b100, 7'd0));
    select(3'b100);
    pay();
    dispense("after_reset");

    repeat (5) tick();
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
